// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM sequencer for a 16-bit CPU.
// Defining CTRL_TRAP_EN makes undefined encodings trap to 16'h0002 and pulse illegal.
module cpu_ctrl (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        write,
  output logic        IMM_MUX,
  output logic        COND_RSLT,
  output logic [1:0]  WB_MUX,
  output logic [3:0]  rSrc,
  output logic [3:0]  rDst,
  output logic [4:0]  aluOp,
  output logic [7:0]  imm_in,
  output logic [15:0] pc_ra,
  input  logic [15:0] dSrc,
  input  logic [15:0] dDst,
  input  logic [4:0]  psr_in,
  output logic [15:0] mem_data,
  output logic        illegal
);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_MEM    = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    K_ILL   = 3'd0,
    K_ALU   = 3'd1,
    K_LOAD  = 3'd2,
    K_STOR  = 3'd3,
    K_JAL   = 3'd4,
    K_JCOND = 3'd5,
    K_BCOND = 3'd6
  } kind_t;

  // psr layout is {L,Z,F,N,C}; unsigned/signed compare codes combine L and N with Z.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [4:0] psr);
    logic l, z, f, n, c;
    l = psr[4];
    z = psr[3];
    f = psr[2];
    n = psr[1];
    c = psr[0];
    case (cond)
      4'h0:    cond_eval = z;
      4'h1:    cond_eval = !z;
      4'h2:    cond_eval = c;
      4'h3:    cond_eval = !c;
      4'h4:    cond_eval = l;
      4'h5:    cond_eval = !l;
      4'h6:    cond_eval = n;
      4'h7:    cond_eval = !n;
      4'h8:    cond_eval = f;
      4'h9:    cond_eval = !f;
      4'hA:    cond_eval = !l && !z;
      4'hB:    cond_eval = l || z;
      4'hC:    cond_eval = !n && !z;
      4'hD:    cond_eval = n || z;
      4'hE:    cond_eval = 1'b1;
      4'hF:    cond_eval = 1'b0;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  state_t      state_r, state_next_s;
  logic [15:0] pc_r, pc_next_s;
  logic [15:0] ir_r, ir_next_s;
  logic        live_r;
  kind_t       kind_s;
  logic [4:0]  alu_op_s;
  logic        imm_mux_s;
  logic        cond_s;
  logic [15:0] disp_s;
`ifdef CTRL_TRAP_EN
  logic        trap_s;
`endif

  // Instruction fields come straight from IR, so they hold from DECODE through MEM.
  assign rDst    = ir_r[11:8];
  assign rSrc    = ir_r[3:0];
  assign imm_in  = ir_r[7:0];
  assign aluOp   = alu_op_s;
  assign IMM_MUX = imm_mux_s;
  assign cond_s  = cond_eval(ir_r[11:8], psr_in);
  assign disp_s  = {{8{ir_r[7]}}, ir_r[7:0]};

`ifdef CTRL_TRAP_EN
  assign illegal = trap_s;
`else
  assign illegal = 1'b0;
`endif

  // State, PC and IR registers; live_r keeps the bus quiet for the cycle after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_FETCH;
      pc_r    <= 16'h0000;
      ir_r    <= 16'h0000;
      live_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      pc_r    <= pc_next_s;
      ir_r    <= ir_next_s;
      live_r  <= 1'b1;
    end
  end

  // Opcode classification and ALU operation select.
  always_comb begin
    kind_s    = K_ILL;
    alu_op_s  = 5'h00;
    imm_mux_s = 1'b0;
    case (ir_r[15:12])
      4'h0: begin
        kind_s   = K_ALU;
        alu_op_s = {1'b0, ir_r[7:4]};
      end
      4'h4: begin
        case (ir_r[7:4])
          4'h0:    kind_s = K_LOAD;
          4'h4:    kind_s = K_STOR;
          4'h8:    kind_s = K_JAL;
          4'hC:    kind_s = K_JCOND;
          default: kind_s = K_ILL;
        endcase
      end
      4'hC:    kind_s = K_BCOND;
      4'hD, 4'hE, 4'hF: kind_s = K_ILL;
      default: begin
        kind_s    = K_ALU;
        alu_op_s  = {1'b0, ir_r[15:12]};
        imm_mux_s = 1'b1;
      end
    endcase
  end

  // Next-state, PC/IR update and bus/write-back outputs.
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    ir_next_s    = ir_r;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = 16'h0000;
    mem_wdata    = 16'h0000;
    write        = 1'b0;
    WB_MUX       = 2'b10;
    COND_RSLT    = 1'b0;
    pc_ra        = 16'h0000;
    mem_data     = 16'h0000;
`ifdef CTRL_TRAP_EN
    trap_s       = 1'b0;
`endif
    case (state_r)
      ST_FETCH: begin
        if (live_r) begin
          mem_req  = 1'b1;
          mem_addr = pc_r;
          if (mem_ack) begin
            ir_next_s    = mem_rdata;
            pc_next_s    = pc_r + 16'd1;
            state_next_s = ST_DECODE;
          end else begin
            state_next_s = ST_FETCH;
          end
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_DECODE: state_next_s = ST_EXEC;
      ST_EXEC: begin
        state_next_s = ST_FETCH;
        case (kind_s)
          K_ALU: begin
            write  = 1'b1;
            WB_MUX = 2'b10;
          end
          K_LOAD, K_STOR: state_next_s = ST_MEM;
          K_JAL: begin
            pc_ra     = pc_r;
            WB_MUX    = 2'b01;
            write     = 1'b1;
            pc_next_s = dSrc;
          end
          K_JCOND: begin
            COND_RSLT = cond_s;
            if (cond_s) begin
              pc_next_s = dSrc;
            end else begin
              pc_next_s = pc_r;
            end
          end
          K_BCOND: begin
            COND_RSLT = cond_s;
            if (cond_s) begin
              pc_next_s = pc_r + disp_s;
            end else begin
              pc_next_s = pc_r;
            end
          end
          K_ILL: begin
`ifdef CTRL_TRAP_EN
            trap_s    = 1'b1;
            pc_next_s = 16'h0002;
`else
            pc_next_s = pc_r;
`endif
          end
          default: pc_next_s = pc_r;
        endcase
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        mem_addr = dSrc;
        if (kind_s == K_STOR) begin
          mem_we    = 1'b1;
          mem_wdata = dDst;
        end else begin
          mem_we    = 1'b0;
        end
        if (mem_ack) begin
          state_next_s = ST_FETCH;
          if (kind_s == K_LOAD) begin
            write    = 1'b1;
            WB_MUX   = 2'b11;
            mem_data = mem_rdata;
          end else begin
            write    = 1'b0;
          end
        end else begin
          state_next_s = ST_MEM;
        end
      end
      default: state_next_s = ST_FETCH;
    endcase
  end

endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 SHALL have clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have mem_req, mem_we  output  1 each  memory request and write strobe.
REQ-004 SHALL have mem_addr, mem_wdata  output  16 each  memory address and store data.
REQ-005 SHALL have mem_ack  input  1  request complete, sampled only while mem_req=1.
REQ-006 SHALL have mem_rdata  input  16  fetch or load data, valid when mem_ack=1.
REQ-007 SHALL have write, IMM_MUX, COND_RSLT  output  1 each  regfile write enable, immediate select, condition result.
REQ-008 SHALL have WB_MUX  output  2  write-back select: 10 ALU, 11 memory, 01 pc_ra.
REQ-009 SHALL have rSrc, rDst  output  4 each; aluOp  output  5; imm_in  output  8; pc_ra  output  16.
REQ-010 SHALL have dSrc, dDst  input  16 each  register read data from the datapath.
REQ-011 SHALL have psr_in  input  5  flags {L,Z,F,N,C}, bit4..bit0.
REQ-012 SHALL have mem_data  output  16  mem_rdata forwarded to the datapath; illegal  output  1  trap pulse.

Function
REQ-013 SHALL sequence states FETCH->DECODE->EXEC, plus MEM for LOAD/STOR, then return to FETCH.
REQ-014 In FETCH, SHALL drive mem_req=1, mem_we=0, mem_addr=PC; hold until mem_ack. On ack, SHALL latch IR=mem_rdata and set PC=PC+1 modulo 2^16.
REQ-015 DECODE SHALL take one cycle: rDst=IR[11:8], rSrc=IR[3:0], imm_in=IR[7:0]. All field outputs SHALL stay stable through EXEC and MEM.
REQ-016 Opcode IR[15:12]=0x0 (R-type) SHALL give aluOp={0,IR[7:4]}, IMM_MUX=0.
REQ-017 Opcodes 0x1-0xB except 0x4 (I-type) SHALL give aluOp={0,IR[15:12]}, IMM_MUX=1.
REQ-018 For ALU ops, EXEC SHALL assert write=1 with WB_MUX=10 for exactly one cycle.
REQ-019 Opcode 0x4 with ext IR[7:4]: 0x0 LOAD, 0x4 STOR, 0x8 JAL, 0xC Jcond. 0xC=Bcond, cond=IR[11:8], displacement=IR[7:0] signed.
REQ-020 Condition codes SHALL evaluate from psr_in as follows:
 0 Z; 1 !Z; 2 C; 3 !C; 4 L; 5 !L; 6 N; 7 !N; 8 F; 9 !F;
 A !L&!Z; B L|Z; C !N&!Z; D N|Z; E 1; F 0.
REQ-021 In EXEC for Bcond/Jcond, COND_RSLT SHALL equal the condition result. If taken: Bcond sets PC=PC+sext(disp) modulo 2^16; Jcond sets PC=dSrc.
REQ-022 JAL EXEC SHALL drive pc_ra=PC (already incremented), WB_MUX=01, write=1, then set PC=dSrc.
REQ-023 MEM SHALL drive mem_req=1, mem_addr=dSrc; STOR adds mem_we=1, mem_wdata=dDst. MEM SHALL hold until ack.
REQ-024 On the LOAD ack cycle, SHALL drive write=1, WB_MUX=11, mem_data=mem_rdata.
REQ-025 Zero-wait latency SHALL be: ALU/branch/JAL 3 cycles; LOAD/STOR 4 cycles per instruction.
REQ-026 mem_ack while mem_req=0 SHALL be ignored. Branch with disp=0 SHALL re-execute at PC+1 normally.

Reset
REQ-027 rst SHALL force FETCH, PC=0, IR=0, all outputs 0 except WB_MUX=10.
REQ-028 rst during a memory handshake SHALL deassert mem_req on the next cycle and discard any pending ack.

Configuration
REQ-029 With CTRL_TRAP_EN defined, an undefined opcode or ext SHALL pulse illegal=1 for one cycle in EXEC, set PC=16'h0002, and perform no write.
REQ-030 Without CTRL_TRAP_EN, undefined encodings SHALL execute as NOP (no write, PC unchanged) and illegal SHALL be tied to 0.

Verification
REQ-031 Reset with zero-wait ack, fetch 0x510A (ADDI r1,10) -> mem_addr=0 in FETCH; EXEC write=1, rDst=1, IMM_MUX=1, imm_in=0x0A, aluOp=5'h05; PC=1.
REQ-032 Fetch 0x4302 (LOAD r3,[r2]) with dSrc=0xFF00, rdata=0x000A -> MEM mem_addr=0xFF00, write=1, WB_MUX=11, mem_data=0x000A.
REQ-033 Fetch 0xC0FE (BEQ -2) at PC=5 with psr_in=01000 -> COND_RSLT=1, next fetch address 4. With psr_in=00000 -> next fetch address 6.
REQ-034 Fetch 0x4E8x (JAL r14) at PC=9 with dSrc=0x0100 -> pc_ra=0x000A, WB_MUX=01, write=1, next fetch 0x0100.
REQ-035 Hold mem_ack=0 for 5 cycles during STOR, then assert rst -> mem_req stays high and stable for 5 cycles, mem_we=1, then drops; PC=0.
REQ-036 Fetch undefined 0x4010 -> illegal pulse and next fetch 0x0002 with CTRL_TRAP_EN defined; no write and next fetch PC+1 without it.
